// File: rtl/nn_layer_seq_pkg.sv
// Shared types and helpers for the runtime-loadable fully-connected layer.
// Holds the FSM state encoding, activation selector and a width-generic saturator.
package nn_pkg;

  typedef enum logic [1:0] {
    ST_ACCUM,
    ST_FLUSH,
    ST_ACT,
    ST_DRAIN
  } state_e;

  typedef enum int {
    ACT_RELU  = 0,
    ACT_IDENT = 1
  } act_e;

  // Clamp a signed value to the range of a w-bit two's-complement number.
  function automatic logic signed [63:0] sat_q(input logic signed [63:0] v,
                                               input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/nn_layer_seq_mac_lane.sv
// One neuron of the layer: weight/bias RAM, 2-stage multiply-accumulate and
// the bias/round/saturate/activation stage that produces the registered result.
module nn_mac_lane
  import nn_pkg::*;
#(
  parameter int NUM_IN = 784,
  parameter int DATA_W = 16,
  parameter int FRAC_W = 12,
  parameter int ACT    = 0,
  parameter int AW     = $clog2(NUM_IN + 1)
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic                     we,
  input  logic [AW-1:0]            wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [AW-1:0]            rd_addr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] x_in,
  input  logic                     clear,
  input  logic                     act_en,
  output logic signed [DATA_W-1:0] result
);

  localparam int ACC_W = 2 * DATA_W + $clog2(NUM_IN);

  logic signed [DATA_W-1:0]   mem [NUM_IN+1];
  logic signed [DATA_W-1:0]   w_q;
  logic signed [DATA_W-1:0]   x_q;
  logic                       v_q;
  logic signed [2*DATA_W-1:0] x_ext;
  logic signed [2*DATA_W-1:0] w_ext;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    acc;
  logic signed [ACC_W:0]      bias_ext;
  logic signed [ACC_W:0]      sum;
  logic signed [ACC_W:0]      shifted;
  logic signed [63:0]         wide;
  logic signed [DATA_W-1:0]   act_out;

  // The RAM is never reset so a loaded layer survives a pipeline reset.
  always_ff @(posedge CLK) begin
    if (we) mem[wr_addr] <= wr_data;
    w_q <= mem[rd_addr];
  end

  always_comb begin
    x_ext    = {{DATA_W{x_q[DATA_W-1]}}, x_q};
    w_ext    = {{DATA_W{w_q[DATA_W-1]}}, w_q};
    prod     = x_ext * w_ext;
    bias_ext = {{(ACC_W + 1 - DATA_W){w_q[DATA_W-1]}}, w_q} <<< FRAC_W;
    sum      = {acc[ACC_W-1], acc} + bias_ext;
    shifted  = sum >>> FRAC_W;
    wide     = {{(63 - ACC_W){shifted[ACC_W]}}, shifted};
    act_out  = DATA_W'(sat_q(wide, DATA_W));
    if (ACT == int'(ACT_RELU) && act_out[DATA_W-1]) act_out = '0;
  end

  // During ACT the read port sits on the bias address, so w_q holds the bias.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      x_q    <= '0;
      v_q    <= 1'b0;
      acc    <= '0;
      result <= '0;
    end else begin
      v_q <= en;
      if (en) x_q <= x_in;
      if (clear)
        acc <= '0;
      else if (v_q)
        acc <= acc + {{(ACC_W - 2 * DATA_W){prod[2*DATA_W-1]}}, prod};
      if (act_en) result <= act_out;
    end
  end

endmodule

// File: rtl/nn_layer_seq.sv
// Fully-connected layer top: sequencing FSM, input counter, load-port gating
// and the serialiser that streams the NN lane results downstream.
module nn_layer_seq
  import nn_pkg::*;
#(
  parameter int NN     = 30,
  parameter int NUM_IN = 784,
  parameter int DATA_W = 16,
  parameter int FRAC_W = 12,
  parameter int ACT    = 0
) (
  input  logic                          CLK,
  input  logic                          RESET_N,
  input  logic                          x_valid,
  output logic                          x_ready,
  input  logic signed [DATA_W-1:0]      x_in,
  output logic                          y_valid,
  input  logic                          y_ready,
  output logic [DATA_W-1:0]             y_data,
  output logic [$clog2(NN)-1:0]         y_idx,
  output logic                          y_last,
  input  logic                          wr_en,
  input  logic [$clog2(NN)-1:0]         wr_lane,
  input  logic [$clog2(NUM_IN+1)-1:0]   wr_addr,
  input  logic [DATA_W-1:0]             wr_data,
  output logic                          busy
);

  localparam int AW = $clog2(NUM_IN + 1);
  localparam int LW = $clog2(NN);
  localparam logic [AW-1:0] LAST_CNT  = AW'(NUM_IN - 1);
  localparam logic [AW-1:0] BIAS_ADDR = AW'(NUM_IN);
  localparam logic [LW-1:0] LAST_IDX  = LW'(NN - 1);

  state_e                   state;
  logic [AW-1:0]            cnt;
  logic                     flush_cnt;
  logic                     accept;
  logic                     clear;
  logic                     act_en;
  logic                     wr_ok;
  logic [AW-1:0]            rd_addr;
  logic [LW-1:0]            next_idx;
  logic signed [DATA_W-1:0] res [NN];

  assign accept   = x_valid & x_ready;
  assign clear    = (state == ST_DRAIN) & y_valid & y_ready & y_last;
  assign act_en   = (state == ST_ACT);
  assign rd_addr  = (state == ST_ACCUM) ? cnt : BIAS_ADDR;
  assign busy     = (state != ST_ACCUM) || (cnt != '0);
  assign next_idx = y_idx + LW'(1);
  assign wr_ok    = wr_en && !busy && (32'(wr_lane) < NN) && (32'(wr_addr) <= NUM_IN);

  for (genvar i = 0; i < NN; i++) begin : g_lane
    nn_mac_lane #(
      .NUM_IN(NUM_IN),
      .DATA_W(DATA_W),
      .FRAC_W(FRAC_W),
      .ACT   (ACT),
      .AW    (AW)
    ) u_lane (
      .CLK    (CLK),
      .RESET_N(RESET_N),
      .we     (wr_ok && (wr_lane == LW'(i))),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .rd_addr(rd_addr),
      .en     (accept),
      .x_in   (x_in),
      .clear  (clear),
      .act_en (act_en),
      .result (res[i])
    );
  end

  // FLUSH spans two cycles so the final product reaches the accumulator and
  // the read port settles on the bias before ACT samples them.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= ST_ACCUM;
      cnt       <= '0;
      flush_cnt <= 1'b0;
      x_ready   <= 1'b0;
      y_valid   <= 1'b0;
      y_data    <= '0;
      y_idx     <= '0;
      y_last    <= 1'b0;
    end else begin
      case (state)
        ST_ACCUM: begin
          x_ready <= 1'b1;
          if (accept) begin
            cnt <= cnt + AW'(1);
            if (cnt == LAST_CNT) begin
              state     <= ST_FLUSH;
              x_ready   <= 1'b0;
              flush_cnt <= 1'b0;
            end
          end
        end
        ST_FLUSH: begin
          flush_cnt <= 1'b1;
          if (flush_cnt) state <= ST_ACT;
        end
        ST_ACT: state <= ST_DRAIN;
        ST_DRAIN: begin
          if (!y_valid) begin
            y_valid <= 1'b1;
            y_data  <= res[0];
            y_idx   <= '0;
            y_last  <= (NN == 1);
          end else if (y_ready) begin
            if (y_last) begin
              y_valid <= 1'b0;
              y_last  <= 1'b0;
              y_idx   <= '0;
              y_data  <= '0;
              cnt     <= '0;
              x_ready <= 1'b1;
              state   <= ST_ACCUM;
            end else begin
              y_idx  <= next_idx;
              y_data <= res[next_idx];
              y_last <= (next_idx == LAST_IDX);
            end
          end
        end
        default: state <= ST_ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_nn_layer_seq.sv
// Directed bench for nn_layer_seq: a ReLU and an identity instance share the
// stimulus and are checked against an arithmetic reference model of the layer.
module tb_nn_layer_seq;

  localparam int NN     = 3;
  localparam int NUM_IN = 4;
  localparam int DATA_W = 16;
  localparam int FRAC_W = 12;

  logic        CLK     = 1'b0;
  logic        RESET_N = 1'b0;
  logic        x_valid = 1'b0;
  logic        y_ready = 1'b1;
  logic        wr_en   = 1'b0;
  logic [15:0] x_in    = '0;
  logic [15:0] wr_data = '0;
  logic [1:0]  wr_lane = '0;
  logic [2:0]  wr_addr = '0;

  logic        x_ready0, y_valid0, y_last0, busy0;
  logic [15:0] y_data0;
  logic [1:0]  y_idx0;
  logic        x_ready1, y_valid1, y_last1, busy1;
  logic [15:0] y_data1;
  logic [1:0]  y_idx1;

  typedef struct {
    logic [15:0] d0;
    logic [15:0] d1;
    int          idx;
    bit          last;
  } exp_t;

  exp_t               exp_q[$];
  exp_t               e;
  logic signed [15:0] wm [NN][NUM_IN+1];
  logic signed [15:0] frame_x [NUM_IN];
  logic [15:0]        cap0 [NN];
  logic [15:0]        cap1 [NN];
  int                 checks = 0;
  int                 errors = 0;
  int                 frames_done = 0;

  always #5 CLK = ~CLK;

  nn_layer_seq #(.NN(NN), .NUM_IN(NUM_IN), .DATA_W(DATA_W), .FRAC_W(FRAC_W), .ACT(0)) dut0 (
    .CLK(CLK), .RESET_N(RESET_N), .x_valid(x_valid), .x_ready(x_ready0), .x_in(x_in),
    .y_valid(y_valid0), .y_ready(y_ready), .y_data(y_data0), .y_idx(y_idx0), .y_last(y_last0),
    .wr_en(wr_en), .wr_lane(wr_lane), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy0));

  nn_layer_seq #(.NN(NN), .NUM_IN(NUM_IN), .DATA_W(DATA_W), .FRAC_W(FRAC_W), .ACT(1)) dut1 (
    .CLK(CLK), .RESET_N(RESET_N), .x_valid(x_valid), .x_ready(x_ready1), .x_in(x_in),
    .y_valid(y_valid1), .y_ready(y_ready), .y_data(y_data1), .y_idx(y_idx1), .y_last(y_last1),
    .wr_en(wr_en), .wr_lane(wr_lane), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy1));

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  // Reference: exact integer dot product, floor shift, clamp, optional ReLU.
  function automatic logic [15:0] model(input int lane, input bit ident);
    longint acc = 0;
    for (int i = 0; i < NUM_IN; i++) acc += longint'(frame_x[i]) * longint'(wm[lane][i]);
    acc += longint'(wm[lane][NUM_IN]) * 4096;
    acc = acc >>> FRAC_W;
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    if (!ident && acc < 0) acc = 0;
    return acc[15:0];
  endfunction

  task automatic write_w(input int lane, input int addr, input logic [15:0] data, input bit honoured);
    wr_en   = 1'b1;
    wr_lane = 2'(lane);
    wr_addr = 3'(addr);
    wr_data = data;
    @(posedge CLK); #1;
    wr_en = 1'b0;
    if (honoured) wm[lane][addr] = data;
  endtask

  task automatic load_lane(input int lane, input logic [15:0] w, input logic [15:0] b);
    for (int a = 0; a < NUM_IN; a++) write_w(lane, a, w, 1'b1);
    write_w(lane, NUM_IN, b, 1'b1);
  endtask

  task automatic set_frame(input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] c, input logic [15:0] d);
    frame_x[0] = a; frame_x[1] = b; frame_x[2] = c; frame_x[3] = d;
    for (int n = 0; n < NN; n++) begin
      cap0[n] = 16'hdead;
      cap1[n] = 16'hdead;
    end
  endtask

  // Sends one frame; returns just after y_valid rises with y_ready still high.
  task automatic applyStimulus(input int gap, input bit inject);
    int tmo;
    int lat;
    for (int i = 0; i < NUM_IN; i++) begin
      for (int g = 0; g < gap; g++) begin
        x_valid = 1'b0;
        @(posedge CLK); #1;
      end
      x_valid = 1'b1;
      x_in    = frame_x[i];
      if (inject && i == 2) begin
        wr_en = 1'b1; wr_lane = 2'd0; wr_addr = 3'd0; wr_data = 16'h3000;
        checkOutput("busy_mid_frame", 32'(busy0), 1);
      end
      tmo = 0;
      while (!x_ready0 && tmo < 50) begin
        @(posedge CLK); #1;
        tmo++;
      end
      if (tmo >= 50) checkOutput("x_ready_timeout", 0, 1);
      @(posedge CLK); #1;
      wr_en = 1'b0;
    end
    x_valid = 1'b0;
    for (int n = 0; n < NN; n++)
      exp_q.push_back(exp_t'{model(n, 1'b0), model(n, 1'b1), n, (n == NN - 1)});
    lat = 0;
    while (!y_valid0 && lat < 20) begin
      @(posedge CLK); #1;
      lat++;
    end
    checkOutput("output_latency", lat, 4);
  endtask

  task automatic wait_frame(input int start);
    int t = 0;
    while (frames_done == start && t < 100) begin
      @(posedge CLK); #1;
      t++;
    end
    if (t >= 100) checkOutput("frame_done_timeout", 0, 1);
    checkOutput("all_results_seen", exp_q.size(), 0);
  endtask

  task automatic wait_idx1();
    int t = 0;
    while (!(y_valid0 && y_idx0 == 2'd1) && t < 20) begin
      @(posedge CLK); #1;
      t++;
    end
    if (t >= 20) checkOutput("idx1_timeout", 0, 1);
  endtask

  task automatic check_caps(input string tag, input logic [15:0] r0, input logic [15:0] r1,
                            input logic [15:0] r2, input logic [15:0] i0,
                            input logic [15:0] i1, input logic [15:0] i2);
    checkOutput({tag, "_relu0"}, cap0[0], r0);
    checkOutput({tag, "_relu1"}, cap0[1], r1);
    checkOutput({tag, "_relu2"}, cap0[2], r2);
    checkOutput({tag, "_ident0"}, cap1[0], i0);
    checkOutput({tag, "_ident1"}, cap1[1], i1);
    checkOutput({tag, "_ident2"}, cap1[2], i2);
  endtask

  // Every accepted output beat is matched in order against the model queue.
  always @(negedge CLK) begin
    if (RESET_N && y_valid0 && y_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_output", 1, 0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("y_data_relu", y_data0, e.d0);
        checkOutput("y_data_ident", y_data1, e.d1);
        checkOutput("y_idx", y_idx0, e.idx);
        checkOutput("y_last", 32'(y_last0), 32'(e.last));
        checkOutput("y_valid_ident", 32'(y_valid1), 1);
        cap0[e.idx] = y_data0;
        cap1[e.idx] = y_data1;
        if (e.last) frames_done++;
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int start;

    $display("[TB] reset");
    RESET_N = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      checkOutput("rst_x_ready", 32'(x_ready0), 0);
      checkOutput("rst_y_valid", 32'(y_valid0), 0);
      checkOutput("rst_y_data", y_data0, 0);
      checkOutput("rst_y_idx", y_idx0, 0);
      checkOutput("rst_y_last", 32'(y_last0), 0);
      checkOutput("rst_busy", 32'(busy0), 0);
    end
    @(posedge CLK); #1;
    RESET_N = 1'b1;
    @(posedge CLK); #1;
    checkOutput("post_rst_x_ready", 32'(x_ready0), 1);
    checkOutput("post_rst_busy", 32'(busy0), 0);

    $display("[TB] nominal frame");
    for (int n = 0; n < NN; n++) load_lane(n, 16'h1000, 16'h0000);
    set_frame(16'h0800, 16'h0800, 16'h0800, 16'h0800);
    start = frames_done;
    applyStimulus(0, 1'b0);
    wait_frame(start);
    check_caps("nominal", 16'h2000, 16'h2000, 16'h2000, 16'h2000, 16'h2000, 16'h2000);

    $display("[TB] nominal frame with input gaps");
    set_frame(16'h0800, 16'h0800, 16'h0800, 16'h0800);
    start = frames_done;
    applyStimulus(2, 1'b0);
    wait_frame(start);
    check_caps("gaps", 16'h2000, 16'h2000, 16'h2000, 16'h2000, 16'h2000, 16'h2000);

    $display("[TB] reset during drain");
    start = frames_done;
    applyStimulus(0, 1'b0);
    wait_idx1();
    RESET_N = 1'b0;
    exp_q.delete();
    #1;
    checkOutput("midrst_y_valid", 32'(y_valid0), 0);
    checkOutput("midrst_y_data", y_data0, 0);
    checkOutput("midrst_y_idx", y_idx0, 0);
    checkOutput("midrst_y_last", 32'(y_last0), 0);
    checkOutput("midrst_busy", 32'(busy0), 0);
    repeat (2) @(posedge CLK);
    #1;
    RESET_N = 1'b1;
    @(posedge CLK); #1;
    checkOutput("midrst_x_ready", 32'(x_ready0), 1);
    set_frame(16'h0800, 16'h0800, 16'h0800, 16'h0800);
    start = frames_done;
    applyStimulus(0, 1'b0);
    wait_frame(start);
    check_caps("after_rst", 16'h2000, 16'h2000, 16'h2000, 16'h2000, 16'h2000, 16'h2000);

    $display("[TB] positive saturation");
    for (int n = 0; n < NN; n++) load_lane(n, 16'h7000, 16'h0000);
    set_frame(16'h7000, 16'h7000, 16'h7000, 16'h7000);
    start = frames_done;
    applyStimulus(0, 1'b0);
    wait_frame(start);
    check_caps("sat_pos", 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);

    $display("[TB] negative saturation and activation");
    for (int n = 0; n < NN; n++) load_lane(n, 16'h9000, 16'h0000);
    set_frame(16'h7000, 16'h7000, 16'h7000, 16'h7000);
    start = frames_done;
    applyStimulus(0, 1'b0);
    wait_frame(start);
    check_caps("sat_neg", 16'h0000, 16'h0000, 16'h0000, 16'h8000, 16'h8000, 16'h8000);

    $display("[TB] truncation toward minus infinity");
    load_lane(0, 16'hFFFF, 16'h0000);
    load_lane(1, 16'h0001, 16'h0000);
    load_lane(2, 16'h1000, 16'h0000);
    set_frame(16'h0001, 16'h0000, 16'h0000, 16'h0000);
    start = frames_done;
    applyStimulus(0, 1'b0);
    wait_frame(start);
    check_caps("trunc", 16'h0000, 16'h0000, 16'h0001, 16'hFFFF, 16'h0000, 16'h0001);

    $display("[TB] backpressure with bias");
    load_lane(0, 16'h1000, 16'h0000);
    load_lane(1, 16'h2000, 16'h0100);
    load_lane(2, 16'hF000, 16'h0000);
    set_frame(16'h0800, 16'h1000, 16'h0400, 16'hFC00);
    start = frames_done;
    applyStimulus(0, 1'b0);
    wait_idx1();
    y_ready = 1'b0;
    repeat (5) begin
      @(negedge CLK);
      checkOutput("bp_y_valid", 32'(y_valid0), 1);
      checkOutput("bp_y_idx", y_idx0, 1);
      checkOutput("bp_y_data", y_data0, 16'h3100);
      checkOutput("bp_y_last", 32'(y_last0), 0);
      checkOutput("bp_x_ready", 32'(x_ready0), 0);
    end
    @(posedge CLK); #1;
    y_ready = 1'b1;
    wait_frame(start);
    check_caps("bp", 16'h1800, 16'h3100, 16'h0000, 16'h1800, 16'h3100, 16'hE800);

    $display("[TB] write protection while busy");
    for (int n = 0; n < NN; n++) load_lane(n, 16'h1000, 16'h0000);
    set_frame(16'h0800, 16'h0800, 16'h0800, 16'h0800);
    start = frames_done;
    applyStimulus(0, 1'b1);
    wait_frame(start);
    check_caps("wp_busy", 16'h2000, 16'h2000, 16'h2000, 16'h2000, 16'h2000, 16'h2000);
    write_w(0, 0, 16'h3000, 1'b1);
    set_frame(16'h0800, 16'h0800, 16'h0800, 16'h0800);
    start = frames_done;
    applyStimulus(0, 1'b0);
    wait_frame(start);
    check_caps("wp_idle", 16'h3000, 16'h2000, 16'h2000, 16'h3000, 16'h2000, 16'h2000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nn_layer_seq.md
# nn_layer_seq

Parametrised, runtime-loadable fully-connected layer for the MNIST inference pipeline. It is the successor to the fixed 30-neuron first layer. It accepts one input activation per handshake and drives NN parallel MAC lanes. It then applies bias, rounding, saturation and a selectable activation, and serialises the NN results onto a valid/ready stream for the next layer. Weights and biases are written through a load port instead of being baked in at synthesis.

## Interface
Parameters:
- NN, 30: neurons (lanes) in the layer.
- NUM_IN, 784: inputs per frame, which is also the weight depth per lane.
- DATA_W, 16: signed width of activations, weights and biases.
- FRAC_W, 12: fractional bits, shared by data and weights (integer part = DATA_W-FRAC_W, so 4 by default).
- ACT, 0: activation; 0 = ReLU, 1 = identity.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- x_valid  in  1  input sample valid.
- x_ready  out  1  layer accepts a sample.
- x_in  in  DATA_W  input activation (signed Q).
- y_valid  out  1  output sample valid.
- y_ready  in  1  downstream accepts.
- y_data  out  DATA_W  activated neuron output.
- y_idx  out  clog2(NN)  neuron index of y_data.
- y_last  out  1  marks the final neuron (y_idx==NN-1).
- wr_en  in  1  weight/bias write strobe.
- wr_lane  in  clog2(NN)  target neuron.
- wr_addr  in  clog2(NUM_IN+1)  input index; the value NUM_IN selects the bias.
- wr_data  in  DATA_W  value to write.
- busy  out  1  frame in progress (any input accepted, or not in ACCUM).

## Operation
States:
- ACCUM: x_ready=1; the input counter cnt runs 0..NUM_IN-1.
- FLUSH: 2 cycles, waits for the MAC pipeline to drain.
- ACT: 1 cycle; computes and registers all NN results.
- DRAIN: emits the results serially.

Transitions:
- Reset leads to ACCUM with cnt=0 and all accumulators cleared.
- ACCUM: each x_valid&x_ready increments cnt. The accept at cnt==NUM_IN-1 goes to FLUSH, and x_ready drops on the next cycle.
- FLUSH goes to ACT, ACT goes to DRAIN.
- DRAIN: each y_valid&y_ready advances y_idx. The handshake with y_last clears the accumulators and cnt and returns to ACCUM.

Arithmetic:
- Product = x*w, 2*DATA_W bits, with 2*FRAC_W fractional bits.
- Accumulator width is 2*DATA_W+clog2(NUM_IN), so it cannot overflow.
- ACT step:
  - sum = acc + (sign-extended bias << FRAC_W).
  - Arithmetic shift right by FRAC_W (truncation toward −inf).
  - Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - If ACT==0, negative results become 0.

Load port:
- A write is honoured only when busy==0; otherwise it is silently dropped.
- A write with wr_lane>=NN or wr_addr>NUM_IN is dropped.
- Weight and bias memories are not cleared by reset.

## Timing
- Reset values: x_ready=0 while RESET_N is low and 1 from the first cycle after release. y_valid=0, y_data=0, y_idx=0, y_last=0, busy=0.
- Weight read is synchronous, so each MAC lane is a 2-stage pipeline (read+multiply registered, then accumulate).
- Latency: y_valid rises after the 4th rising edge following the edge that accepts the last sample (2 FLUSH, 1 ACT, 1 entering DRAIN).
- DRAIN throughput: one result per cycle while y_ready=1.
- Backpressure: while y_ready=0, y_data, y_idx and y_last are held, and x_ready stays 0.
- x_valid gaps in ACCUM: the counter and accumulators hold.
- RESET_N asserted mid-frame, in any state: immediate return to reset values and the partial frame is discarded.

## Structure
- Package nn_pkg holds:
  - the act_e enum (ACT_RELU, ACT_IDENT);
  - the sat_q function (width-generic saturation);
  - the state_e enum.
- Sub-module nn_mac_lane, instantiated NN times via generate, contains:
  - a (NUM_IN+1)xDATA_W weight/bias RAM;
  - the multiply stage, the accumulator, and the bias/shift/saturate/activation stage.
- The top level holds the FSM, cnt, the output mux and the serialiser.

## Test plan
Configuration for all scenarios: NN=3, NUM_IN=4, DATA_W=16, FRAC_W=12.

1. Reset: hold RESET_N low for 3 cycles, then release. Required: all outputs 0 during reset, x_ready=1 on the next cycle, busy=0.
2. Nominal frame: all weights 0x1000, biases 0, four inputs of 0x0800. Required: y_data = 0x2000 for idx 0, 1, 2; y_last only on idx 2; y_valid on the 4th edge after the last accept.
3. Saturation and activation:
   - Weights 0x7000, inputs 0x7000: every output is 0x7FFF.
   - Weights 0x9000 (negative): every output is 0 with ACT=0, and 0x8000 with ACT=1.
4. Backpressure: drop y_ready for 5 cycles at idx 1. Required: y_data and y_idx stable, x_ready=0, and no result lost or duplicated.
5. Busy write protection: issue a write to lane 0, addr 0 when cnt==2. Required: it is ignored and the result equals the old-weight value. The same write made while idle takes effect on the next frame.
6. Reset mid-DRAIN at idx 1. Required: outputs return to 0. A following frame with the same inputs reproduces the scenario 2 results, since the weights are retained.
